// File: rtl/alu_operand_sequencer_if.sv
// Board-side and ALU-side signal bundle for alu_operand_sequencer.
// The sequencer uses the slave view; the board/ALU side (or a bench) uses master.
interface alu_operand_sequencer_if;
    logic [3:0] sw;
    logic       btn_next;
    logic       btn_clr;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [3:0] opcode;
    logic [7:0] alu_y;
    logic [7:0] disp_val;
    logic       disp_sel;
    logic [2:0] step;
    logic       res_valid;

    modport master (
        output sw, btn_next, btn_clr, alu_y,
        input  op_a, op_b, opcode, disp_val, disp_sel, step, res_valid
    );

    modport slave (
        input  sw, btn_next, btn_clr, alu_y,
        output op_a, op_b, opcode, disp_val, disp_sel, step, res_valid
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Switch/pushbutton front-end for the ALU demo: sync, debounce, 5-state operand entry FSM.
// Optional macro OPERAND_PREVIEW_SIGNED_EN shows A/B entry as sign-extended values.
module alu_operand_sequencer #(
    parameter int DEB_CYCLES = 1000000,
    parameter int CNT_W      = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_operand_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_RES  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [3:0]       r_sw_m, r_sw_s;
    logic [1:0]       r_btn_m, r_btn_s;
    logic [CNT_W-1:0] r_cnt [2];
    logic [1:0]       r_lvl, r_lvl_q, r_arm, r_warm;
    logic [1:0]       w_pls;
    logic             w_nx_pls, w_cl_pls;

    state_t     r_state, w_state_nx;
    logic [3:0] r_op_a, r_op_b, r_opcode;
    logic [7:0] r_res, r_disp_val, w_disp_val_nx;
    logic       r_disp_sel, w_disp_sel_nx;
    logic       w_ld_a, w_ld_b, w_ld_op, w_cap;

    // Index 0 = next, 1 = clr. A button is armed only once it has been seen
    // released after reset, so a press held through reset never fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_m  <= '0;
            r_sw_s  <= '0;
            r_btn_m <= '0;
            r_btn_s <= '0;
            r_lvl   <= '0;
            r_lvl_q <= '0;
            r_arm   <= '0;
            r_warm  <= '0;
            for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
        end else begin
            r_sw_m  <= bus.sw;
            r_sw_s  <= r_sw_m;
            r_btn_m <= {bus.btn_clr, bus.btn_next};
            r_btn_s <= r_btn_m;
            r_warm  <= {r_warm[0], 1'b1};
            r_lvl_q <= r_lvl;
            for (int i = 0; i < 2; i++) begin
                if (r_btn_s[i] == r_lvl[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DEB_LAST) begin
                    r_lvl[i] <= r_btn_s[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
                if (r_warm[1] && !r_btn_s[i]) r_arm[i] <= 1'b1;
            end
        end
    end

    assign w_pls    = r_lvl & ~r_lvl_q & r_arm;
    assign w_nx_pls = w_pls[0];
    assign w_cl_pls = w_pls[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_A;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        if (w_cl_pls) begin
            w_state_nx = S_A;
        end else begin
            case (r_state)
                S_A:     if (w_nx_pls) w_state_nx = S_B;
                S_B:     if (w_nx_pls) w_state_nx = S_OP;
                S_OP:    if (w_nx_pls) w_state_nx = S_EXEC;
                S_EXEC:  w_state_nx = S_RES;
                S_RES:   if (w_nx_pls) w_state_nx = S_A;
                default: w_state_nx = S_A;
            endcase
        end
    end

    always_comb begin
        w_ld_a        = !w_cl_pls && w_nx_pls && (r_state == S_A);
        w_ld_b        = !w_cl_pls && w_nx_pls && (r_state == S_B);
        w_ld_op       = !w_cl_pls && w_nx_pls && (r_state == S_OP);
        w_cap         = !w_cl_pls && (r_state == S_EXEC);
        w_disp_sel_nx = 1'b1;
        w_disp_val_nx = {4'b0000, r_sw_s};
        case (r_state)
            S_RES: begin
                w_disp_sel_nx = 1'b0;
                w_disp_val_nx = r_res;
            end
`ifdef OPERAND_PREVIEW_SIGNED_EN
            S_A, S_B: begin
                w_disp_sel_nx = 1'b0;
                w_disp_val_nx = {{4{r_sw_s[3]}}, r_sw_s};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_opcode   <= '0;
            r_res      <= '0;
            r_disp_val <= '0;
            r_disp_sel <= 1'b1;
        end else begin
            if (w_cl_pls) begin
                r_op_a   <= '0;
                r_op_b   <= '0;
                r_opcode <= '0;
                r_res    <= '0;
            end else begin
                if (w_ld_a)  r_op_a   <= r_sw_s;
                if (w_ld_b)  r_op_b   <= r_sw_s;
                if (w_ld_op) r_opcode <= r_sw_s;
                if (w_cap)   r_res    <= bus.alu_y;
            end
            r_disp_sel <= w_disp_sel_nx;
            r_disp_val <= w_disp_val_nx;
        end
    end

    assign bus.op_a      = r_op_a;
    assign bus.op_b      = r_op_b;
    assign bus.opcode    = r_opcode;
    assign bus.disp_val  = r_disp_val;
    assign bus.disp_sel  = r_disp_sel;
    assign bus.step      = r_state;
    assign bus.res_valid = w_cap;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: directed scenarios plus random entry/clear sequences
// checked against an abstract model of the entry procedure.
module tb_alu_operand_sequencer;
    localparam int DEB = 4;
    localparam int CW  = 3;
    localparam int HOLD = DEB + 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_operand_sequencer_if bus();

    alu_operand_sequencer #(.DEB_CYCLES(DEB), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int rv_cnt = 0;
    int rv_exp = 0;
    int mstep = 0;
    logic [3:0] ma = '0, mb = '0, mop = '0;
    logic [7:0] mres = '0;

    function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] op);
        case (op)
            4'd0:    return {4'h0, a & b};
            4'd1:    return {4'h0, a | b};
            4'd2:    return {4'h0, a} + {4'h0, b};
            4'd3:    return {4'h0, a ^ b};
            default: return {a, b};
        endcase
    endfunction

    always_comb bus.alu_y = alu_ref(bus.op_a, bus.op_b, bus.opcode);

    always @(negedge clk) if (bus.res_valid === 1'b1) rv_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic nx, input logic cl);
        bus.btn_next = nx;
        bus.btn_clr  = cl;
        repeat (HOLD) @(negedge clk);
        bus.btn_next = 1'b0;
        bus.btn_clr  = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic model_next();
        case (mstep)
            0: begin ma = bus.sw; mstep = 1; end
            1: begin mb = bus.sw; mstep = 2; end
            2: begin mop = bus.sw; mres = alu_ref(ma, mb, mop); rv_exp++; mstep = 4; end
            default: mstep = 0;
        endcase
    endtask

    task automatic model_clr();
        ma = '0; mb = '0; mop = '0; mres = '0; mstep = 0;
    endtask

    task automatic exp_disp(input int st, input logic [3:0] s, output logic sel,
                            output logic [7:0] val);
        if (st == 4) begin
            sel = 1'b0; val = mres;
        end else begin
            sel = 1'b1; val = {4'h0, s};
`ifdef OPERAND_PREVIEW_SIGNED_EN
            if (st < 2) begin sel = 1'b0; val = {{4{s[3]}}, s}; end
`endif
        end
    endtask

    task automatic check_all(input string tag);
        logic       esel;
        logic [7:0] eval;
        exp_disp(mstep, bus.sw, esel, eval);
        check({tag, ".step"},     32'(bus.step),     32'(mstep));
        check({tag, ".op_a"},     32'(bus.op_a),     32'(ma));
        check({tag, ".op_b"},     32'(bus.op_b),     32'(mb));
        check({tag, ".opcode"},   32'(bus.opcode),   32'(mop));
        check({tag, ".disp_sel"}, 32'(bus.disp_sel), 32'(esel));
        check({tag, ".disp_val"}, 32'(bus.disp_val), 32'(eval));
        check({tag, ".rv_cnt"},   32'(rv_cnt),       32'(rv_exp));
    endtask

    initial begin
        logic       esel;
        logic [7:0] eval;
        int         lat;
        bit         found;

        // Reset with both buttons held
        bus.sw = 4'h0; bus.btn_next = 1'b1; bus.btn_clr = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.step",     32'(bus.step),      32'd0);
        check("rst.op_a",     32'(bus.op_a),      32'd0);
        check("rst.opcode",   32'(bus.opcode),    32'd0);
        check("rst.disp_sel", 32'(bus.disp_sel),  32'd1);
        check("rst.disp_val", 32'(bus.disp_val),  32'd0);
        check("rst.res_vld",  32'(bus.res_valid), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_all("rst_held");
        bus.btn_next = 1'b0; bus.btn_clr = 1'b0;
        repeat (HOLD) @(negedge clk);
        check_all("rst_idle");

        // Full entry 5, 3, add
        bus.sw = 4'd5; press(1'b1, 1'b0); model_next(); check_all("entry_a");
        bus.sw = 4'd3; press(1'b1, 1'b0); model_next(); check_all("entry_b");
        bus.sw = 4'd2; press(1'b1, 1'b0); model_next(); check_all("entry_op");
        check("entry.op_a",     32'(bus.op_a),     32'd5);
        check("entry.op_b",     32'(bus.op_b),     32'd3);
        check("entry.opcode",   32'(bus.opcode),   32'd2);
        check("entry.step",     32'(bus.step),     32'd4);
        check("entry.disp_sel", 32'(bus.disp_sel), 32'd0);
        check("entry.disp_val", 32'(bus.disp_val), 32'h08);
        check("entry.rv_cnt",   32'(rv_cnt),       32'd1);
        bus.sw = 4'd7; press(1'b1, 1'b0); model_next(); check_all("res_to_a");

        // Bounce: 2 high / 1 low bursts, then a steady press
        bus.sw = 4'(($urandom) % 16);
        for (int k = 0; k < 7; k++) begin
            bus.btn_next = 1'b1; repeat (2) @(negedge clk);
            bus.btn_next = 1'b0; @(negedge clk);
        end
        check("bounce.no_adv", 32'(bus.step), 32'd0);
        bus.btn_next = 1'b1;
        lat = 0; found = 1'b0;
        for (int i = 1; i <= 40 && !found; i++) begin
            @(negedge clk);
            if (bus.step == 3'd1) begin found = 1'b1; lat = i; end
        end
        check("bounce.found", 32'(found), 32'd1);
        check("bounce.latency", 32'(lat), 32'(DEB + 3));
        repeat (HOLD) @(negedge clk);
        bus.btn_next = 1'b0;
        repeat (HOLD) @(negedge clk);
        model_next(); check_all("bounce_done");

        // Live preview in S_B
        bus.sw = 4'd0; repeat (5) @(negedge clk);
        bus.sw = 4'd9;
        repeat (2) @(negedge clk);
        exp_disp(1, 4'd0, esel, eval);
        check("preview.old_val", 32'(bus.disp_val), 32'(eval));
        @(negedge clk);
        exp_disp(1, 4'd9, esel, eval);
        check("preview.sel", 32'(bus.disp_sel), 32'(esel));
        check("preview.val", 32'(bus.disp_val), 32'(eval));

        // Clear and next together in S_OP
        press(1'b1, 1'b0); model_next(); check_all("to_op");
        bus.sw = 4'd3;
        press(1'b1, 1'b1); model_clr(); check_all("clr_prio");

        // Reset while in S_EXEC
        bus.sw = 4'd6; press(1'b1, 1'b0); model_next();
        bus.sw = 4'd2; press(1'b1, 1'b0); model_next();
        bus.sw = 4'd1; bus.btn_next = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #2;
            if (bus.step == 3'd3) found = 1'b1;
        end
        check("exec.found", 32'(found), 32'd1);
        check("exec.res_vld", 32'(bus.res_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst.step",     32'(bus.step),      32'd0);
        check("arst.res_vld",  32'(bus.res_valid), 32'd0);
        check("arst.op_a",     32'(bus.op_a),      32'd0);
        check("arst.disp_sel", 32'(bus.disp_sel),  32'd1);
        check("arst.disp_val", 32'(bus.disp_val),  32'd0);
        bus.btn_next = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clr();
        repeat (HOLD) @(negedge clk);
        check_all("arst_idle");

        // Random entry / clear sequences
        for (int r = 0; r < 16; r++) begin
            bus.sw = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                press(1'b0, 1'b1); model_clr();
            end else begin
                press(1'b1, 1'b0); model_next();
            end
            check_all($sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Upstream front-end of the FPGA ALU demo: turns 4 slide switches and 2 raw pushbuttons into a stepwise operand/opcode entry sequence.
- Drives the ALU's operand and opcode inputs, captures the 8-bit ALU result, and produces the value and mode word for the 7-segment decoder stage.
- Synchronises and debounces all board inputs. Runs a 5-state entry FSM.

Parameters:
DEB_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); must be >= 2
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sw  input  4  raw slide switches (operand / opcode entry)
btn_next  input  1  raw pushbutton, advance step
btn_clr  input  1  raw pushbutton, clear and restart
op_a  output  4  latched operand A to ALU
op_b  output  4  latched operand B to ALU
opcode  output  4  latched opcode to ALU
alu_y  input  8  ALU result (combinational from op_a/op_b/opcode)
disp_val  output  8  value for the digital tube decoder A input
disp_sel  output  1  decoder mode: 1 = 4-bit binary, 0 = 8-bit signed decimal
step  output  3  one-hot-free state code for LEDs: 0=A, 1=B, 2=OP, 3=EXEC, 4=RES
res_valid  output  1  one-cycle pulse when the result is captured

Behaviour:
- Reset (async assert, sync release): all registers clear. op_a=op_b=opcode=0, result register=0, disp_val=0, disp_sel=1, step=0 (S_A), res_valid=0. Sync and debounce state cleared, so no button pulse is issued on release.
- Synchronisers: sw, btn_next and btn_clr each pass through 2 flops (sw_s, nx_s, cl_s). All downstream logic uses only the synchronised values.
- Debounce (per button):
  - Counter resets to 0 whenever the synced input equals the accepted level.
  - Otherwise the counter increments. When the counter equals DEB_CYCLES-1 and the input still differs, the accepted level takes the input value and the counter returns to 0.
  - A glitch shorter than DEB_CYCLES cycles is ignored.
  - Press pulse = accepted level rising edge; exactly one cycle per press.
  - Latency: pulse is high on clock DEB_CYCLES+2 after the raw input is first sampled high.
  - Release produces no pulse.
- FSM, acting in the cycle the pulse is high:
  - S_A: next -> op_a<=sw_s, go S_B.
  - S_B: next -> op_b<=sw_s, go S_OP.
  - S_OP: next -> opcode<=sw_s, go S_EXEC.
  - S_EXEC: unconditional, one cycle. Result register<=alu_y, res_valid=1 for this cycle, go S_RES.
  - S_RES: next -> go S_A. op_a, op_b and opcode are retained; the result register is retained.
  - clr pulse in any state: op_a=op_b=opcode=0, result=0, go S_A.
  - clr and next in the same cycle: clr wins.
  - next pulse during S_EXEC is dropped.
- Display outputs are registered, updated every cycle, one-cycle latency from state/sw_s:
  - S_A, S_B, S_OP, S_EXEC: disp_sel=1, disp_val={4'b0000, sw_s}.
  - S_RES: disp_sel=0, disp_val=result register.
- step is registered and equals the current state code. Codes 5-7 are unreachable; if ever decoded, go S_A.

Optional Feature:
- Macro: OPERAND_PREVIEW_SIGNED_EN.
- Defined: in S_A and S_B, disp_sel=0 and disp_val is sw_s sign-extended to 8 bits (sw=4'b1101 shows -3). S_OP and S_EXEC still use binary mode.
- Undefined: behaviour as specified above.

Test Plan (DEB_CYCLES=4):
- Reset: hold rst_n=0 with buttons pressed, then release -> all outputs at reset values, no res_valid, step=0; buttons held through release produce no pulse until released and re-pressed.
- Full entry: sw=5, press next; sw=3, press next; sw=opcode 2, press next; bench ALU model returns alu_y=8'h08 -> op_a=5, op_b=3, opcode=2, res_valid pulse exactly once, step=4, disp_sel=0, disp_val=8'h08.
- Bounce rejection: btn_next toggles high 2 cycles / low 1 cycle for 20 cycles, then held high -> exactly one advance, pulse DEB_CYCLES+2 clocks after the last sampled rising edge.
- Clear priority: in S_OP, assert clr and next pulses in the same cycle -> step=0, op_a=op_b=opcode=0, opcode not loaded.
- Live preview: in S_B, change sw 0->9 -> disp_val=8'h09, disp_sel=1 one cycle after sw_s changes; with OPERAND_PREVIEW_SIGNED_EN -> disp_val=8'hF9, disp_sel=0.
- Mid-operation reset: assert rst_n=0 during S_EXEC -> outputs clear immediately without waiting for clk; res_valid=0.
